// File: rtl/mac_ip_arp_tx_mux.sv
// mac_ip_arp_tx_mux
//   Transmit-side packet mux that feeds the MAC TX framer from two byte
//   streams (IP and ARP). One whole packet is granted at a time. The packet
//   goes out with its ethertype. After each packet's last beat the mux holds
//   a programmable idle gap, so the framer has room for preamble and FCS.
//
//   Parameters
//     P_GAP_CYCLES : idle cycles after a last beat before the next grant
//                    (0 = back-to-back)
//     P_TYPE_IP    : ethertype driven for IP packets
//     P_TYPE_ARP   : ethertype driven for ARP packets
//
//   Optional build macro
//     ARP_PRIORITY_EN : ARP wins every tie in IDLE. There is no round-robin
//                       pointer. A packet in flight is never preempted.
//
//   Ports
//     i_clk, i_rst        : clock, synchronous active-high reset
//     i_ip_*  / o_ip_ready  : IP source stream (valid/ready/last, 8-bit data)
//     i_arp_* / o_arp_ready : ARP source stream
//     o_mac_type/data/valid/last : registered stream to the framer. It shows
//                                  each beat one cycle after acceptance.
module mac_ip_arp_tx_mux #(
  parameter int          P_GAP_CYCLES = 12,
  parameter logic [15:0] P_TYPE_IP    = 16'h0800,
  parameter logic [15:0] P_TYPE_ARP   = 16'h0806
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_ip_data,
  input  logic        i_ip_valid,
  input  logic        i_ip_last,
  output logic        o_ip_ready,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_valid,
  input  logic        i_arp_last,
  output logic        o_arp_ready,
  output logic [15:0] o_mac_type,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_valid,
  output logic        o_mac_last
);

  typedef enum logic [1:0] {S_IDLE, S_SEND_IP, S_SEND_ARP, S_GAP} state_t;

  localparam int LP_CW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
  localparam logic [LP_CW-1:0] LP_GAP_LAST =
    LP_CW'((P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [LP_CW-1:0] r_gap_cnt, w_gap_nxt;
  logic             w_ip_acc, w_arp_acc;
  state_t           w_after_last;

  logic [15:0] r_mac_type;
  logic [7:0]  r_mac_data;
  logic        r_mac_valid;
  logic        r_mac_last;

  // The readies decode straight from the registered state, so they carry no
  // combinational path from the source valids.
  assign o_ip_ready  = (r_state == S_SEND_IP);
  assign o_arp_ready = (r_state == S_SEND_ARP);
  assign w_ip_acc    = o_ip_ready  & i_ip_valid;
  assign w_arp_acc   = o_arp_ready & i_arp_valid;
  assign w_after_last = (P_GAP_CYCLES > 0) ? S_GAP : S_IDLE;

`ifndef ARP_PRIORITY_EN
  // 1 = ARP was granted most recently. The reset value makes the first tie go to ARP.
  logic r_rr_arp, w_rr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rr_arp <= 1'b0;
    else       r_rr_arp <= w_rr_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
`ifndef ARP_PRIORITY_EN
    w_rr_nxt    = r_rr_arp;
`endif
    case (r_state)
      S_IDLE: begin
        w_gap_nxt = '0;
`ifdef ARP_PRIORITY_EN
        if (i_arp_valid)     w_state_nxt = S_SEND_ARP;
        else if (i_ip_valid) w_state_nxt = S_SEND_IP;
`else
        if (i_ip_valid && i_arp_valid) begin
          w_state_nxt = r_rr_arp ? S_SEND_IP : S_SEND_ARP;
          w_rr_nxt    = ~r_rr_arp;
        end else if (i_arp_valid) begin
          w_state_nxt = S_SEND_ARP;
          w_rr_nxt    = 1'b1;
        end else if (i_ip_valid) begin
          w_state_nxt = S_SEND_IP;
          w_rr_nxt    = 1'b0;
        end
`endif
      end
      S_SEND_IP: begin
        if (w_ip_acc && i_ip_last) begin
          w_state_nxt = w_after_last;
          w_gap_nxt   = '0;
        end
      end
      S_SEND_ARP: begin
        if (w_arp_acc && i_arp_last) begin
          w_state_nxt = w_after_last;
          w_gap_nxt   = '0;
        end
      end
      S_GAP: begin
        // Source valids are ignored here. The gap length is fixed.
        if (r_gap_cnt == LP_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt   = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Output register. On a bubble, type holds only while the grant is still
  // in SEND. Once the state has left SEND (the beat after last) it clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mac_type  <= '0;
      r_mac_data  <= '0;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
    end else if (w_ip_acc) begin
      r_mac_type  <= P_TYPE_IP;
      r_mac_data  <= i_ip_data;
      r_mac_valid <= 1'b1;
      r_mac_last  <= i_ip_last;
    end else if (w_arp_acc) begin
      r_mac_type  <= P_TYPE_ARP;
      r_mac_data  <= i_arp_data;
      r_mac_valid <= 1'b1;
      r_mac_last  <= i_arp_last;
    end else begin
      r_mac_data  <= '0;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      if (r_state != S_SEND_IP && r_state != S_SEND_ARP) r_mac_type <= '0;
    end
  end

  assign o_mac_type  = r_mac_type;
  assign o_mac_data  = r_mac_data;
  assign o_mac_valid = r_mac_valid;
  assign o_mac_last  = r_mac_last;

endmodule

// File: tb/tb_mac_ip_arp_tx_mux.sv
module tb_mac_ip_arp_tx_mux;
  localparam int GAP = 12;
`ifdef ARP_PRIORITY_EN
  localparam bit TIE2_ARP = 1'b1;
`else
  localparam bit TIE2_ARP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  ip_data = '0, arp_data = '0;
  logic        ip_valid = 1'b0, ip_last = 1'b0, arp_valid = 1'b0, arp_last = 1'b0;
  logic        ip_ready, arp_ready, mac_valid, mac_last;
  logic [15:0] mac_type;
  logic [7:0]  mac_data;

  // Second instance with no gap, driven by the ARP port only.
  logic [7:0]  a0_data = '0;
  logic        a0_valid = 1'b0, a0_last = 1'b0;
  logic        z_ip_ready, z_arp_ready, z_valid, z_last;
  logic [15:0] z_type;
  logic [7:0]  z_data;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mac_ip_arp_tx_mux #(.P_GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ip_data(ip_data), .i_ip_valid(ip_valid), .i_ip_last(ip_last), .o_ip_ready(ip_ready),
    .i_arp_data(arp_data), .i_arp_valid(arp_valid), .i_arp_last(arp_last), .o_arp_ready(arp_ready),
    .o_mac_type(mac_type), .o_mac_data(mac_data), .o_mac_valid(mac_valid), .o_mac_last(mac_last));

  mac_ip_arp_tx_mux #(.P_GAP_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_ip_data(8'h00), .i_ip_valid(1'b0), .i_ip_last(1'b0), .o_ip_ready(z_ip_ready),
    .i_arp_data(a0_data), .i_arp_valid(a0_valid), .i_arp_last(a0_last), .o_arp_ready(z_arp_ready),
    .o_mac_type(z_type), .o_mac_data(z_data), .o_mac_valid(z_valid), .o_mac_last(z_last));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic [15:0] t);
    chk({tag, "_valid"}, 16'(mac_valid), 16'd1);
    chk({tag, "_data"},  16'(mac_data), 16'(d));
    chk({tag, "_last"},  16'(mac_last), 16'(l));
    chk({tag, "_type"},  mac_type, t);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt [4];
    pkt[0] = 8'h45; pkt[1] = 8'h00; pkt[2] = 8'h00; pkt[3] = 8'h1C;

    // reset state
    do_reset();
    chk("rst_ip_ready", 16'(ip_ready), 16'd0);
    chk("rst_arp_ready", 16'(arp_ready), 16'd0);
    chk("rst_type", mac_type, 16'h0000);
    chk("rst_data", 16'(mac_data), 16'h0000);
    chk("rst_valid", 16'(mac_valid), 16'd0);
    chk("rst_last", 16'(mac_last), 16'd0);

    // IP only, 4 bytes, then gap, then a single-byte packet
    ip_valid = 1'b1; ip_data = pkt[0]; ip_last = 1'b0;
    step();
    chk("t1_ready_rise", 16'(ip_ready), 16'd1);
    chk("t1_no_beat_yet", 16'(mac_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      ip_data = pkt[i]; ip_last = (i == 3);
      step();
      beat("t1_beat", pkt[i], (i == 3), 16'h0800);
    end
    ip_data = 8'hAA; ip_last = 1'b1;
    chk("t1_ready_after_last", 16'(ip_ready), 16'd0);
    for (int g = 0; g < GAP; g++) begin
      step();
      chk("t1_gap_ready", 16'(ip_ready), 16'd0);
      chk("t1_gap_valid", 16'(mac_valid), 16'd0);
      chk("t1_gap_type", mac_type, 16'h0000);
    end
    step();
    chk("t1_regrant", 16'(ip_ready), 16'd1);
    step();
    beat("t1_single", 8'hAA, 1'b1, 16'h0800);
    ip_valid = 1'b0; ip_last = 1'b0;
    step();
    chk("t1_type_clear", mac_type, 16'h0000);

    // tie after reset: ARP first, then a second tie
    do_reset();
    ip_valid = 1'b1; ip_data = 8'h11; ip_last = 1'b1;
    arp_valid = 1'b1; arp_data = 8'h21; arp_last = 1'b1;
    step();
    chk("t2_tie1_arp_ready", 16'(arp_ready), 16'd1);
    chk("t2_tie1_ip_ready", 16'(ip_ready), 16'd0);
    step();
    beat("t2_arp1", 8'h21, 1'b1, 16'h0806);
    arp_data = 8'h22;
    for (int g = 0; g < GAP; g++) begin
      step();
      chk("t2_gap_ip_ready", 16'(ip_ready), 16'd0);
      chk("t2_gap_arp_ready", 16'(arp_ready), 16'd0);
    end
    step();
    chk("t2_tie2_ip_ready", 16'(ip_ready), 16'(!TIE2_ARP));
    chk("t2_tie2_arp_ready", 16'(arp_ready), 16'(TIE2_ARP));
    step();
    if (TIE2_ARP) begin
      beat("t2_tie2_win", 8'h22, 1'b1, 16'h0806);
      arp_valid = 1'b0;
    end else begin
      beat("t2_tie2_win", 8'h11, 1'b1, 16'h0800);
      ip_valid = 1'b0;
    end
    for (int g = 0; g < GAP; g++) step();
    step();
    chk("t2_loser_ready", 16'(TIE2_ARP ? ip_ready : arp_ready), 16'd1);
    step();
    if (TIE2_ARP) beat("t2_loser", 8'h11, 1'b1, 16'h0800);
    else          beat("t2_loser", 8'h22, 1'b1, 16'h0806);
    ip_valid = 1'b0; arp_valid = 1'b0;

    // IP bubble of 3 cycles with ARP waiting, no interleave
    do_reset();
    ip_valid = 1'b1; ip_data = 8'hA1; ip_last = 1'b0;
    step();
    chk("t4_ip_ready", 16'(ip_ready), 16'd1);
    arp_valid = 1'b1; arp_data = 8'hB1; arp_last = 1'b1;
    step();
    beat("t4_b1", 8'hA1, 1'b0, 16'h0800);
    ip_data = 8'hA2;
    step();
    beat("t4_b2", 8'hA2, 1'b0, 16'h0800);
    ip_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("t4_bubble_valid", 16'(mac_valid), 16'd0);
      chk("t4_bubble_data", 16'(mac_data), 16'h0000);
      chk("t4_bubble_type", mac_type, 16'h0800);
      chk("t4_bubble_arp_ready", 16'(arp_ready), 16'd0);
    end
    ip_valid = 1'b1; ip_data = 8'hA3;
    step();
    beat("t4_b3", 8'hA3, 1'b0, 16'h0800);
    ip_data = 8'hA4; ip_last = 1'b1;
    step();
    beat("t4_b4", 8'hA4, 1'b1, 16'h0800);
    ip_valid = 1'b0; ip_last = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      step();
      chk("t5_arp_held", 16'(arp_ready), 16'd0);
    end
    step();
    chk("t5_arp_ready", 16'(arp_ready), 16'd1);
    step();
    beat("t5_arp", 8'hB1, 1'b1, 16'h0806);
    arp_valid = 1'b0; arp_last = 1'b0;

    // reset mid-packet
    do_reset();
    ip_valid = 1'b1; ip_data = 8'hC0; ip_last = 1'b0;
    step();
    step();
    beat("t6_b1", 8'hC0, 1'b0, 16'h0800);
    ip_data = 8'hC1;
    step();
    beat("t6_b2", 8'hC1, 1'b0, 16'h0800);
    ip_data = 8'hC2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_ready", 16'(ip_ready), 16'd0);
    chk("t6_rst_valid", 16'(mac_valid), 16'd0);
    chk("t6_rst_last", 16'(mac_last), 16'd0);
    chk("t6_rst_data", 16'(mac_data), 16'h0000);
    chk("t6_rst_type", mac_type, 16'h0000);
    ip_data = 8'hD0; ip_last = 1'b1;
    step();
    chk("t6_fresh_ready", 16'(ip_ready), 16'd1);
    step();
    beat("t6_fresh", 8'hD0, 1'b1, 16'h0800);
    ip_valid = 1'b0; ip_last = 1'b0;

    // back-to-back ARP with zero gap
    do_reset();
    a0_valid = 1'b1; a0_data = 8'hE0; a0_last = 1'b0;
    step();
    chk("t3_ready", 16'(z_arp_ready), 16'd1);
    step();
    chk("t3_e0", 16'(z_data), 16'h00E0);
    a0_data = 8'hE1; a0_last = 1'b1;
    step();
    chk("t3_e1_last", 16'(z_last), 16'd1);
    chk("t3_e1_type", z_type, 16'h0806);
    a0_data = 8'hF0;
    step();
    chk("t3_gap0_valid", 16'(z_valid), 16'd0);
    chk("t3_gap0_ready", 16'(z_arp_ready), 16'd1);
    step();
    chk("t3_f0_valid", 16'(z_valid), 16'd1);
    chk("t3_f0_data", 16'(z_data), 16'h00F0);
    chk("t3_f0_last", 16'(z_last), 16'd1);
    chk("t3_f0_type", z_type, 16'h0806);
    a0_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_ip_arp_tx_mux.md
Name: mac_ip_arp_tx_mux

Overview:
- Transmit-side counterpart of the MAC receive ethertype demux.
- Arbitrates between the IP TX byte stream and the ARP TX byte stream and grants one whole packet at a time.
- Forwards the granted packet to the MAC TX framer with the matching ethertype (0x0800 IP, 0x0806 ARP).
- Enforces a programmable idle gap between packets so the MAC framer can insert preamble/FCS.

Parameters:
- P_GAP_CYCLES, 12, idle cycles forced after each packet's last beat before the next grant (0 = back-to-back allowed).
- P_TYPE_IP, 16'h0800, ethertype emitted for IP packets.
- P_TYPE_ARP, 16'h0806, ethertype emitted for ARP packets.

Ports:
- i_clk  input  1  single clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_ip_data  input  8  IP TX byte.
- i_ip_valid  input  1  IP byte valid.
- i_ip_last  input  1  final IP byte of packet.
- o_ip_ready  output  1  IP beat accepted when valid & ready.
- i_arp_data  input  8  ARP TX byte.
- i_arp_valid  input  1  ARP byte valid.
- i_arp_last  input  1  final ARP byte of packet.
- o_arp_ready  output  1  ARP beat accepted when valid & ready.
- o_mac_type  output  16  ethertype of packet in flight.
- o_mac_data  output  8  byte to MAC framer.
- o_mac_valid  output  1  byte valid.
- o_mac_last  output  1  final byte of packet.

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, gap counter=0, RR pointer=IP (so the first tie grants ARP).
  - All outputs are 0 the cycle after reset: ready, type, data, valid, last.
- Reset mid-packet aborts the packet: no o_mac_last is emitted and the sources see ready drop.
- States: IDLE, SEND_IP, SEND_ARP, GAP. The state is registered and the readies decode directly from it.
  - o_ip_ready=1 only in SEND_IP; o_arp_ready=1 only in SEND_ARP.
- IDLE:
  - If only one source has valid=1, go to that SEND state.
  - If both have valid=1, grant the source not served last (round robin) and update the pointer on grant.
  - If neither is valid, stay in IDLE.
  - No beat is accepted in IDLE; the source holds its first byte until ready.
- SEND_x, on the granted source's valid & ready:
  - Next cycle: o_mac_data=source data, o_mac_valid=1, o_mac_last=source last, o_mac_type=P_TYPE_x.
  - Output latency is exactly 1 cycle from acceptance.
- SEND_x, no accept (source valid=0): next cycle o_mac_valid=0, o_mac_data=0, o_mac_last=0.
  - The bubble propagates and the grant is held.
- o_mac_type holds P_TYPE_x from the first output beat through the last beat, then returns to 0 the cycle after last.
- Accept with last=1: next state is GAP if P_GAP_CYCLES>0, else IDLE. Ready is low the following cycle.
- GAP: the counter counts P_GAP_CYCLES cycles, then the state goes to IDLE. Source valids are ignored during GAP.
- Minimum IDLE→first output: source valid at cycle 0, ready at cycle 1, output beat at cycle 2.
- Non-granted source valid is never accepted, whatever its last/valid pattern.
- Single-byte packet (valid & last on the first beat) is legal: one output beat with valid=1 and last=1.

Optional Feature:
- Macro ARP_PRIORITY_EN.
- Defined: fixed priority. ARP always wins a tie in IDLE; the RR pointer is not implemented. An ARP packet never preempts an IP packet already in flight.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- IP only, 4 bytes 45 00 00 1C with last on byte 4:
  - o_ip_ready rises 1 cycle after valid.
  - o_mac_data shows 45,00,00,1C on consecutive cycles, o_mac_type=0800, last on 1C.
  - Gap of 12 cycles follows.
- IP and ARP both valid in IDLE after reset:
  - ARP (0806) is sent first, then the gap, then IP.
  - Second tie: IP first (ARP first if ARP_PRIORITY_EN).
- Back-to-back ARP packets with P_GAP_CYCLES=0: second packet's first byte appears 2 cycles after the first packet's last.
- IP source drops valid for 3 cycles mid-packet: o_mac_valid=0 for exactly 3 cycles, o_mac_type stays 0800, o_arp_ready stays 0.
- ARP valid asserted during an IP packet: ARP is not accepted until IP last plus the gap; no byte interleaving.
- i_rst pulsed after byte 2 of a 10-byte IP packet: next cycle all outputs 0, no o_mac_last; after release the block accepts a fresh packet normally.
